key_demux: RTL and testbench

//  Key-indexed demultiplexer with buffering: the write-side counterpart of the key-select
//  mux used across npc. One input stream carries {key, data}; each beat is routed to

---
 rtl/key_demux_pkg.sv | 10 +
 rtl/key_demux_slot.sv | 50 +++++
 rtl/key_demux.sv | 83 ++++++++
 tb/tb_key_demux.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/key_demux_pkg.sv
// Shared constants for the key-indexed demux and its per-channel slot FIFOs.
// Latency: n/a (constants only). Backpressure: n/a.
// Slot depth and drop counter width are fixed here so both files agree.
package key_demux_pkg;

    localparam int DROP_CNT_W    = 8;
    localparam int KD_SLOT_DEPTH = 2;
    localparam int KD_CNT_W      = $clog2(KD_SLOT_DEPTH + 1);

endpackage

// File: rtl/key_demux_slot.sv
// Two-entry in-order FIFO slot with a registered head entry.
// Latency: push into an empty slot is visible at head one cycle later.
// Backpressure: push ignored when full even if pop is high; pop ignored when empty.
module key_demux_slot
    import key_demux_pkg::*;
#(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_LEN-1:0] din,
    output logic [KD_CNT_W-1:0] count,
    output logic [DATA_LEN-1:0] head
);

    localparam logic [KD_CNT_W-1:0] DEPTH = KD_CNT_W'(KD_SLOT_DEPTH);

    logic [DATA_LEN-1:0] tail;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = pop  & (count != '0);
    assign do_push = push & (count != DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == '0) head <= din;
                    else             tail <= din;
                    count <= count + KD_CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - KD_CNT_W'(1);
                end
                // Only reachable at count 1: old head leaves, new beat takes its place.
                2'b11: head <= din;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/key_demux.sv
// Routes {key, data} beats to per-key 2-deep slots; out-of-range keys are dropped and counted.
// Latency: 1 cycle from acceptance to out_valid when the target slot is empty.
// Backpressure: in_ready drops only when the addressed slot is full; no out_ready to in_ready path.
module key_demux
    import key_demux_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [KEY_LEN-1:0]           in_key,
    input  logic [DATA_LEN-1:0]          in_data,
    output logic [NR_KEY-1:0]            out_valid,
    input  logic [NR_KEY-1:0]            out_ready,
    output logic [NR_KEY*DATA_LEN-1:0]   out_data,
    output logic                         miss,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    localparam logic [KD_CNT_W-1:0] DEPTH = KD_CNT_W'(KD_SLOT_DEPTH);

    if (NR_KEY < 1 || NR_KEY > 2**KEY_LEN) begin : g_bad_nr_key
        $error("key_demux: NR_KEY=%0d out of range for KEY_LEN=%0d", NR_KEY, KEY_LEN);
    end

    logic                hit;
    logic                sel_full;
    logic                accept;
    logic [NR_KEY-1:0]   push;
    logic [KD_CNT_W-1:0] cnt  [NR_KEY];
    logic [DATA_LEN-1:0] head [NR_KEY];

    // A full key space makes every beat a hit, so skip the compare entirely.
    if (NR_KEY == 2**KEY_LEN) begin : g_hit_all
        assign hit = 1'b1;
    end else begin : g_hit_cmp
        assign hit = (in_key < KEY_LEN'(NR_KEY));
    end

    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (in_key == KEY_LEN'(i)) sel_full = (cnt[i] == DEPTH);
        end
    end

    assign in_ready = ~(hit & sel_full);
    assign accept   = in_valid & in_ready;

    for (genvar g = 0; g < NR_KEY; g++) begin : g_slot
        assign push[g] = accept & hit & (in_key == KEY_LEN'(g));

        key_demux_slot #(
            .DATA_LEN (DATA_LEN)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (out_valid[g] & out_ready[g]),
            .din   (in_data),
            .count (cnt[g]),
            .head  (head[g])
        );

        assign out_valid[g]                        = (cnt[g] != '0);
        assign out_data[g*DATA_LEN +: DATA_LEN]    = head[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            miss <= accept & ~hit;
            if (accept & ~hit & (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_key_demux.sv
// Directed bench for key_demux: routing, backpressure, push/pop overlap, miss counting, reset.
// A second instance with NR_KEY=3 exercises the out-of-range drop path.
module tb_key_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_key = '0;
    logic [7:0]  in_data = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic        miss;
    logic [7:0]  drop_cnt;

    logic        v3 = 1'b0;
    logic        rdy3;
    logic [1:0]  key3 = '0;
    logic [7:0]  dat3 = '0;
    logic [2:0]  ovld3;
    logic [2:0]  ordy3 = '0;
    logic [23:0] odat3;
    logic        miss3;
    logic [7:0]  drop3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    key_demux #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .miss(miss), .drop_cnt(drop_cnt)
    );

    key_demux #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(8)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_key(key3),
        .in_data(dat3), .out_valid(ovld3), .out_ready(ordy3), .out_data(odat3),
        .miss(miss3), .drop_cnt(drop3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
        vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_out_data got %h want 0", out_data); end
        vectors++; if (miss !== 1'b0) begin miscompares++; $display("FAIL reset_miss got %b want 0", miss); end
        vectors++; if (drop_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_drop_cnt got %h want 00", drop_cnt); end
        vectors++; if (ovld3 !== 3'b000 || drop3 !== 8'h00) begin miscompares++; $display("FAIL reset_dut3 got vld=%b drop=%h want 000/00", ovld3, drop3); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready = 4'b1111;
        in_valid = 1'b1; in_key = 2'd2; in_data = 8'hA5;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0100) begin miscompares++; $display("FAIL single_out_valid got %b want 0100", out_valid); end
        vectors++; if (out_data[23:16] !== 8'hA5) begin miscompares++; $display("FAIL single_slice2 got %h want a5", out_data[23:16]); end
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL single_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_backpressure();
        step();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_key = 2'd1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_second_ready got %b want 1", in_ready); end
        step();
        in_data = 8'h33;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_third_ready got %b want 0", in_ready); end
        step();
        in_key = 2'd0; in_data = 8'h44;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_other_key_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0011) begin miscompares++; $display("FAIL bp_valid got %b want 0011", out_valid); end
        vectors++; if (out_data[7:0] !== 8'h44 || out_data[15:8] !== 8'h11) begin miscompares++; $display("FAIL bp_heads got s0=%h s1=%h want 44/11", out_data[7:0], out_data[15:8]); end
        // Release channel 1 while re-offering 8'h33; slot is still full this cycle.
        out_ready = 4'b1111;
        in_valid = 1'b1; in_key = 2'd1; in_data = 8'h33;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_no_passthrough got %b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (out_data[15:8] !== 8'h22 || out_valid[1] !== 1'b1) begin miscompares++; $display("FAIL bp_second_head got %h/%b want 22/1", out_data[15:8], out_valid[1]); end
        vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL bp_ch0_drained got %b want 0", out_valid[0]); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reopen got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (out_data[15:8] !== 8'h33 || out_valid[1] !== 1'b1) begin miscompares++; $display("FAIL bp_third_head got %h/%b want 33/1", out_data[15:8], out_valid[1]); end
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL bp_empty got %b want 0000", out_valid); end
    endtask

    task automatic test_push_pop();
        out_ready = 4'b0111;
        in_valid = 1'b1; in_key = 2'd3; in_data = 8'h77;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid[3] !== 1'b1 || out_data[31:24] !== 8'h77) begin miscompares++; $display("FAIL pp_first got %b/%h want 1/77", out_valid[3], out_data[31:24]); end
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (out_valid[3] !== 1'b1 || out_data[31:24] !== 8'h5A) begin miscompares++; $display("FAIL pp_replace got %b/%h want 1/5a", out_valid[3], out_data[31:24]); end
        @(negedge clk);
        vectors++; if (out_valid[3] !== 1'b0) begin miscompares++; $display("FAIL pp_no_dup got %b want 0", out_valid[3]); end
    endtask

    task automatic test_miss();
        int bad_ready = 0;
        int bad_miss = 0;
        int bad_vld = 0;
        step();
        ordy3 = 3'b000;
        v3 = 1'b1; key3 = 2'd3; dat3 = 8'hEE;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy3 !== 1'b1) bad_ready++;
            if (i > 0 && miss3 !== 1'b1) bad_miss++;
            if (ovld3 !== 3'b000) bad_vld++;
            if (i == 5) begin
                vectors++; if (drop3 !== 8'd5) begin miscompares++; $display("FAIL miss_count5 got %0d want 5", drop3); end
            end
            dat3 = dat3 + 8'd1;
        end
        @(posedge clk);
        #1 v3 = 1'b0;
        @(negedge clk);
        vectors++; if (bad_ready != 0) begin miscompares++; $display("FAIL miss_in_ready bad cycles %0d want 0", bad_ready); end
        vectors++; if (bad_miss != 0) begin miscompares++; $display("FAIL miss_pulse bad cycles %0d want 0", bad_miss); end
        vectors++; if (bad_vld != 0) begin miscompares++; $display("FAIL miss_out_valid bad cycles %0d want 0", bad_vld); end
        vectors++; if (drop3 !== 8'hFF) begin miscompares++; $display("FAIL miss_saturate got %h want ff", drop3); end
        vectors++; if (miss3 !== 1'b1) begin miscompares++; $display("FAIL miss_last_pulse got %b want 1", miss3); end
        @(negedge clk);
        vectors++; if (miss3 !== 1'b0) begin miscompares++; $display("FAIL miss_clear got %b want 0", miss3); end
        vectors++; if (miss !== 1'b0 || drop_cnt !== 8'h00) begin miscompares++; $display("FAIL full_keyspace got miss=%b drop=%h want 0/00", miss, drop_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'b0000;
        in_valid = 1'b1; in_key = 2'd0; in_data = 8'h01;
        step();
        in_key = 2'd2; in_data = 8'h02;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0101) begin miscompares++; $display("FAIL rst_mid_pre got %b want 0101", out_valid); end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 4'b0000 || out_data !== 32'h0) begin miscompares++; $display("FAIL rst_mid_async got %b/%h want 0000/0", out_valid, out_data); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_key = 2'd2; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hC3) begin miscompares++; $display("FAIL rst_mid_after got %b/%h want 0100/c3", out_valid, out_data[23:16]); end
        @(negedge clk);
        vectors++; if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_no_replay got %b want 0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_push_pop();
        test_miss();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
